image_frame_sequencer: RTL and testbench
========================================

# image_frame_sequencer

Frame-level controller for the pixel-pair image datapath. It sequences one frame per `start` pulse and generates the VSYNC start-up interval, the per-line HSYNC gaps, and the row/column/memory address of each pixel pair. It advances through pixel pairs under a valid/ready handshake from the downstream writer. It sits between the image memory/processing datapath, which it addresses, and the BMP writer, which consumes `HSYNC` and the pixel data.

## Interface
- `WIDTH`, 768: pixels per row; must be even.
- `HEIGHT`, 512: rows per frame.
- `START_UP_DELAY`, 100: VSYNC state length in cycles; range 1..65535.
- `HSYNC_DELAY`, 160: inter-line gap length in cycles; range 1..65535.
- `ADDR_W`, 19: pixel-index width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.

Ports:
- `HCLK`  in  1  clock; the only clock.
- `HRESET`  in  1  reset; synchronous, active-high.
- `start`  in  1  frame request; sampled only in IDLE.
- `abort`  in  1  cancels the frame in progress; returns to IDLE with no `ctrl_done`.
- `out_ready`  in  1  downstream accepts the current pair.
- `out_valid`  out  1  current pair (`rd_addr`, `row`, `col`) is valid.
- `rd_addr`  out  ADDR_W  pixel index of the even pixel of the pair; the odd pixel is `rd_addr+1`.
- `row`  out  10  logical row index, 0..HEIGHT-1.
- `col`  out  11  even column index, 0..WIDTH-2.
- `VSYNC`  out  1  high while in the VSYNC state.
- `HSYNC`  out  1  high while in the DATA state (line active).
- `busy`  out  1  high in any state other than IDLE.
- `ctrl_done`  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, VSYNC, HSYNC, DATA, DONE. All outputs are registered or decoded from the state only, with no combinational path from inputs.
- IDLE → VSYNC when `start`=1. `start` is ignored in every other state.
- VSYNC: the delay counter runs for exactly START_UP_DELAY cycles, then → HSYNC.
- HSYNC (gap): the delay counter runs for exactly HSYNC_DELAY cycles, then → DATA. The counter clears on every state entry.
- DATA: `out_valid`=1.
  - A beat completes on `out_valid && out_ready`.
  - On a beat: `col` += 2. At `col`=WIDTH-2, `col` wraps to 0 and `row` += 1.
  - Beat at `col`=WIDTH-2 with `row`<HEIGHT-1 → HSYNC.
  - Beat at `col`=WIDTH-2 with `row`=HEIGHT-1 → DONE.
  - `out_ready`=0 holds all outputs and counters unchanged. There is no timeout.
- DONE: `ctrl_done`=1 for one cycle, `row`/`col` clear to 0, → IDLE.
- `abort`=1 in any non-IDLE state → IDLE next cycle; `row`, `col` and the counter clear. `abort` has priority over every transition, including DONE.
- Address: `rd_addr` = `row`*WIDTH + `col`, or the mirrored form under the macro in Configuration. It is computed with ADDR_W-bit unsigned arithmetic, and the product never overflows given the ADDR_W rule.
- `HRESET` mid-frame behaves as `abort` and also clears all registers.

## Timing
- Reset values: state IDLE; `out_valid`, `VSYNC`, `HSYNC`, `busy`, `ctrl_done` = 0; `rd_addr`, `row`, `col` = 0.
- `start` high at edge t: `VSYNC`=1 for cycles t+1 .. t+START_UP_DELAY.
- First `out_valid` at cycle t+1+START_UP_DELAY+HSYNC_DELAY.
- Unstalled frame: START_UP_DELAY + HEIGHT*(HSYNC_DELAY + WIDTH/2) cycles, then 1 DONE cycle.
- The next `start` is accepted on the cycle after `ctrl_done`.
- Handshake: the outputs presented in cycle n belong to the beat accepted in cycle n. The next pair appears in cycle n+1.

## Configuration
- `BOTTOM_UP_SCAN_EN` defined: `rd_addr` = (HEIGHT-1-`row`)*WIDTH + `col`. This reads the memory bottom-row first, matching the bottom-up BMP hex row order. `row` output stays logical (0 first).
- Not defined: `rd_addr` = `row`*WIDTH + `col`.

## Structure
- Package `img_seq_pkg`:
  - state enum `seq_state_t` (IDLE, VSYNC, HSYNC, DATA, DONE);
  - default constants `IMG_WIDTH`, `IMG_HEIGHT`, `IMG_START_UP_DELAY`, `IMG_HSYNC_DELAY`.
- One sub-module, `sync_delay_counter`:
  - 16-bit, clear-on-load counter with a `hit` output at the programmed length;
  - shared by the VSYNC and HSYNC states.

## Test plan
Bench parameters: WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2.
- Reset: assert `HRESET` 2 cycles with `start`=1 → all outputs 0, `busy`=0; `start` during reset is not latched.
- Full frame, `out_ready`=1:
  - `start` pulse at t → `VSYNC` high t+1..t+3;
  - first `out_valid` at t+6 with `rd_addr` 0,2,4,6;
  - 2-cycle gap, then 8..14, and so on;
  - last `rd_addr`=30, `ctrl_done` at t+28 → 28 cycles from start to `ctrl_done`, i.e. 27 active (3+4*(2+4)) + 1 DONE.
- Backpressure: `out_ready`=0 for 5 cycles while `rd_addr`=4 → `rd_addr`, `row`, `col`, `out_valid` held; the sequence resumes at 6; `ctrl_done` is delayed by exactly 5 cycles.
- Ignored start: pulse `start` in VSYNC, in DATA and in DONE → no restart, frame length unchanged; a `start` on the cycle after `ctrl_done` launches a new frame.
- Abort: `abort`=1 at `row`=2, `col`=4 → next cycle IDLE, all outputs 0, no `ctrl_done`. `HRESET` at the same point → identical response.
- `BOTTOM_UP_SCAN_EN` defined → first-beat `rd_addr` of each row = 24, 16, 8, 0; `row` output still 0..3.

Source files
------------

// File: rtl/image_frame_sequencer_pkg.sv
// ============================================================================
// Module  : img_seq_pkg
// Brief   : Frame sequencer state encoding and default image geometry.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package img_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VSYNC = 3'd1,
    S_HSYNC = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  localparam int IMG_WIDTH          = 768;
  localparam int IMG_HEIGHT         = 512;
  localparam int IMG_START_UP_DELAY = 100;
  localparam int IMG_HSYNC_DELAY    = 160;

endpackage

`default_nettype wire

// File: rtl/image_frame_sequencer_if.sv
// ============================================================================
// Module  : image_frame_sequencer_if
// Brief   : Control, pixel-pair handshake and sync signals of the sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface image_frame_sequencer_if #(
  parameter int ADDR_W = 19
);
  logic              start;
  logic              abort;
  logic              out_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [9:0]        row;
  logic [10:0]       col;
  logic              VSYNC;
  logic              HSYNC;
  logic              busy;
  logic              ctrl_done;

  modport master (
    input  start, abort, out_ready,
    output out_valid, rd_addr, row, col, VSYNC, HSYNC, busy, ctrl_done
  );

  modport slave (
    output start, abort, out_ready,
    input  out_valid, rd_addr, row, col, VSYNC, HSYNC, busy, ctrl_done
  );
endinterface

`default_nettype wire

// File: rtl/image_frame_sequencer_sync_delay_counter.sv
// ============================================================================
// Module  : sync_delay_counter
// Brief   : 16-bit clear-on-load delay counter; hit marks the last cycle.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sync_delay_counter (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        clear,
  input  wire logic        enable,
  input  wire logic [15:0] length,
  output logic             hit
);
  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= 16'd0;
    end else if (enable) begin
      r_count <= r_count + 16'd1;
    end
  end

  // Independent of enable so the FSM's next-state logic has no loop through it
  assign hit = (r_count == (length - 16'd1));
endmodule

`default_nettype wire

// File: rtl/image_frame_sequencer.sv
// ============================================================================
// Module  : image_frame_sequencer
// Brief   : Frame controller: VSYNC start-up, per-line gaps, pair addressing.
//           Macro BOTTOM_UP_SCAN_EN selects bottom-row-first memory addressing.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module image_frame_sequencer
  import img_seq_pkg::*;
#(
  parameter int WIDTH          = IMG_WIDTH,
  parameter int HEIGHT         = IMG_HEIGHT,
  parameter int START_UP_DELAY = IMG_START_UP_DELAY,
  parameter int HSYNC_DELAY    = IMG_HSYNC_DELAY,
  parameter int ADDR_W         = 19
) (
  input  wire logic                 HCLK,
  input  wire logic                 HRESET,
  image_frame_sequencer_if.master   bus
);
  localparam logic [15:0] c_su_len  = 16'(START_UP_DELAY);
  localparam logic [15:0] c_hs_len  = 16'(HSYNC_DELAY);
  localparam logic [10:0] c_col_end = 11'(WIDTH - 2);
  localparam logic [9:0]  c_row_end = 10'(HEIGHT - 1);

  seq_state_t        r_state, w_state_n;
  logic [9:0]        r_row, w_row_n;
  logic [10:0]       r_col, w_col_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic              w_cnt_clear, w_cnt_en, w_hit;
  logic [15:0]       w_len;

  function automatic logic [ADDR_W-1:0] pair_addr(input logic [9:0] r, input logic [10:0] c);
`ifdef BOTTOM_UP_SCAN_EN
    pair_addr = (ADDR_W'(HEIGHT - 1) - ADDR_W'(r)) * ADDR_W'(WIDTH) + ADDR_W'(c);
`else
    pair_addr = ADDR_W'(r) * ADDR_W'(WIDTH) + ADDR_W'(c);
`endif
  endfunction

  assign w_len = (r_state == S_VSYNC) ? c_su_len : c_hs_len;

  sync_delay_counter u_delay (
    .clk    (HCLK),
    .rst    (HRESET),
    .clear  (w_cnt_clear),
    .enable (w_cnt_en),
    .length (w_len),
    .hit    (w_hit)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_row   <= 10'd0;
      r_col   <= 11'd0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_col   <= w_col_n;
      r_addr  <= w_addr_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_row_n     = r_row;
    w_col_n     = r_col;
    w_cnt_clear = 1'b1;
    w_cnt_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_n = S_VSYNC;
      end
      S_VSYNC, S_HSYNC: begin
        w_cnt_clear = w_hit;
        w_cnt_en    = 1'b1;
        if (w_hit) w_state_n = (r_state == S_VSYNC) ? S_HSYNC : S_DATA;
      end
      S_DATA: begin
        if (bus.out_ready) begin
          if (r_col == c_col_end) begin
            w_col_n = 11'd0;
            // Last pair of the frame clears row now so DONE never shows HEIGHT
            if (r_row == c_row_end) begin
              w_row_n   = 10'd0;
              w_state_n = S_DONE;
            end else begin
              w_row_n   = r_row + 10'd1;
              w_state_n = S_HSYNC;
            end
          end else begin
            w_col_n = r_col + 11'd2;
          end
        end
      end
      S_DONE: begin
        w_row_n   = 10'd0;
        w_col_n   = 11'd0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase

    if (bus.abort && (r_state != S_IDLE)) begin
      w_state_n   = S_IDLE;
      w_row_n     = 10'd0;
      w_col_n     = 11'd0;
      w_cnt_clear = 1'b1;
      w_cnt_en    = 1'b0;
    end

    w_addr_n = (w_state_n == S_IDLE) ? '0 : pair_addr(w_row_n, w_col_n);
  end

  assign bus.out_valid = (r_state == S_DATA);
  assign bus.HSYNC     = (r_state == S_DATA);
  assign bus.VSYNC     = (r_state == S_VSYNC);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ctrl_done = (r_state == S_DONE);
  assign bus.rd_addr   = r_addr;
  assign bus.row       = r_row;
  assign bus.col       = r_col;
endmodule

`default_nettype wire

// File: tb/tb_image_frame_sequencer.sv
// ============================================================================
// Module  : tb_image_frame_sequencer
// Brief   : Directed bench for image_frame_sequencer on an 8x4 frame.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_image_frame_sequencer;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int SU = 3;
  localparam int HS = 2;
  localparam int AW = 8;

  logic HCLK = 1'b0;
  logic HRESET;
  int   checks = 0;
  int   errors = 0;

  image_frame_sequencer_if #(.ADDR_W(AW)) bus ();

  image_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SU), .HSYNC_DELAY(HS), .ADDR_W(AW)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int beat);
    int r, c;
    r = beat / (W / 2);
    c = (beat % (W / 2)) * 2;
`ifdef BOTTOM_UP_SCAN_EN
    return (H - 1 - r) * W + c;
`else
    return r * W + c;
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(bus.busy),      0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_vsync"}, 32'(bus.VSYNC),     0);
    chk({tag, "_hsync"}, 32'(bus.HSYNC),     0);
    chk({tag, "_done"},  32'(bus.ctrl_done), 0);
    chk({tag, "_addr"},  32'(bus.rd_addr),   0);
    chk({tag, "_row"},   32'(bus.row),       0);
    chk({tag, "_col"},   32'(bus.col),       0);
  endtask

  // Entered in the cycle after the start edge; returns that cycle-relative done index
  task automatic run_frame(input int stall_beat, input int stall_cycles,
                           input bit poke_start, output int done_cycle);
    int beat = 0, stalled = 0, vs = 0, vs_last = 0, first_valid = 0, hs = 0;
    done_cycle = 0;
    for (int k = 1; k <= 300; k++) begin
      bus.start = poke_start && (k == 2 || k == 7);
      if (bus.VSYNC) begin vs++; vs_last = k; end
      if (bus.HSYNC) hs++;
      if (bus.out_valid) begin
        if (first_valid == 0) first_valid = k;
        chk("beat_addr", 32'(bus.rd_addr), 32'(exp_addr(beat)));
        chk("beat_row",  32'(bus.row),     32'(beat / (W / 2)));
        chk("beat_col",  32'(bus.col),     32'((beat % (W / 2)) * 2));
        if (beat == stall_beat && stalled < stall_cycles) begin
          bus.out_ready = 1'b0;
          stalled++;
        end else begin
          bus.out_ready = 1'b1;
          beat++;
        end
      end
      if (bus.ctrl_done) begin
        done_cycle = k;
        bus.start = poke_start;
        tick();
        bus.start = 1'b0;
        break;
      end
      tick();
    end
    bus.out_ready = 1'b1;
    chk("frame_vsync_cycles", 32'(vs), SU);
    chk("frame_vsync_last",   32'(vs_last), SU);
    chk("frame_first_valid",  32'(first_valid), 1 + SU + HS);
    chk("frame_beats",        32'(beat), W * H / 2);
    chk("frame_hsync_cycles", 32'(hs), W * H / 2 + stall_cycles);
  endtask

  task automatic abort_at(input bit use_reset, input string tag);
    bit found = 0;
    int dones = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (bus.out_valid && bus.row == 10'd2 && bus.col == 11'd4) begin
        found = 1;
        break;
      end
      tick();
    end
    chk({tag, "_reach_point"}, 32'(found), 1);
    if (use_reset) HRESET = 1'b1; else bus.abort = 1'b1;
    tick();
    HRESET    = 1'b0;
    bus.abort = 1'b0;
    chk_idle(tag);
    for (int k = 0; k < 40; k++) begin
      if (bus.ctrl_done || bus.busy) dones++;
      tick();
    end
    chk({tag, "_no_done"}, 32'(dones), 0);
  endtask

  initial begin
    int d;
    HRESET        = 1'b1;
    bus.start     = 1'b1;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    HRESET    = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("reset_start_not_latched", 32'(bus.busy), 0);

    // Plain frame
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_frame(-1, 0, 1'b0, d);
    chk("plain_done_cycle", 32'(d), SU + H * (HS + W / 2) + 1);
    chk("plain_back_idle", 32'(bus.busy), 0);

    // Backpressure at the third pair of row 0
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_frame(2, 5, 1'b0, d);
    chk("stall_done_cycle", 32'(d), SU + H * (HS + W / 2) + 1 + 5);

    // Start pulses in VSYNC, DATA and DONE are ignored
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_frame(-1, 0, 1'b1, d);
    chk("ignored_start_done_cycle", 32'(d), 28);
    chk("ignored_start_done_idle", 32'(bus.busy), 0);

    // Start on the cycle after ctrl_done launches the next frame
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_vsync", 32'(bus.VSYNC), 1);
    run_frame(-1, 0, 1'b0, d);
    chk("restart_done_cycle", 32'(d), 28);

    abort_at(1'b0, "abort");
    abort_at(1'b1, "hreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
